// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared encodings for the memory/writeback stage
package mem_wb_stage_pkg;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_IMM  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/load_formatter.sv
// rtl/load_formatter.sv - aligns and sign/zero-extends a load word for RV32I load sizes
module load_formatter
    import mem_wb_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] formatted
);

    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    always_comb begin
        loadByte = rdata[7:0];
        case (addr_lo)
            2'd0: loadByte = rdata[7:0];
            2'd1: loadByte = rdata[15:8];
            2'd2: loadByte = rdata[23:16];
            2'd3: loadByte = rdata[31:24];
        endcase
        // Halfword selection ignores addr_lo[0]; misaligned halves are not split.
        loadHalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   formatted = {{24{loadByte[7]}}, loadByte};
            F3_LBU:  formatted = {24'h0, loadByte};
            F3_LH:   formatted = {{16{loadHalf[15]}}, loadHalf};
            F3_LHU:  formatted = {16'h0, loadHalf};
            F3_LW:   formatted = rdata;
            default: formatted = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory/writeback stage driving the register-file write port
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_reg_write,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [1:0]            in_wb_sel,
    input  logic [2:0]            in_funct3,
    input  logic [1:0]            in_addr_lo,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_pc_plus4,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  enableWrite,
    output logic [REG_ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0]     writeData,
    output logic                  wb_busy
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]           retire_count
`endif
);

    wb_state_t             state;
    logic                  pendRegWrite;
    logic [REG_ADDR_W-1:0] pendRd;
    logic [2:0]            pendFunct3;
    logic [1:0]            pendAddrLo;

    logic                  waiting;
    logic                  acceptIdle;
    logic                  retire;
    logic                  wrRegWrite;
    logic [REG_ADDR_W-1:0] wrRd;
    logic [DATA_W-1:0]     wrData;
    logic [DATA_W-1:0]     loadData;
    logic [2:0]            fmtFunct3;
    logic [1:0]            fmtAddrLo;

    assign waiting    = (state == WAIT_LOAD);
    assign in_ready   = (state == IDLE) && rst;
    assign wb_busy    = waiting;
    assign acceptIdle = !waiting && in_valid && !flush;
    assign fmtFunct3  = waiting ? pendFunct3 : in_funct3;
    assign fmtAddrLo  = waiting ? pendAddrLo : in_addr_lo;

    load_formatter u_load_formatter (
        .rdata     (mem_rdata),
        .funct3    (fmtFunct3),
        .addr_lo   (fmtAddrLo),
        .formatted (loadData)
    );

    // A retirement is either a same-cycle accept (non-load, or load with data
    // ready) or the data return of a pending load; flush vetoes both.
    always_comb begin
        retire = (acceptIdle && ((in_wb_sel != WB_LOAD) || mem_rvalid))
              || (waiting && !flush && mem_rvalid);
        wrRegWrite = in_reg_write;
        wrRd       = in_rd;
        wrData     = in_alu_result;
        if (waiting) begin
            wrRegWrite = pendRegWrite;
            wrRd       = pendRd;
            wrData     = loadData;
        end else begin
            case (in_wb_sel)
                WB_ALU:  wrData = in_alu_result;
                WB_LOAD: wrData = loadData;
                WB_PC4:  wrData = in_pc_plus4;
                WB_IMM:  wrData = in_imm;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            enableWrite  <= 1'b0;
            writeReg     <= '0;
            writeData    <= '0;
            pendRegWrite <= 1'b0;
            pendRd       <= '0;
            pendFunct3   <= '0;
            pendAddrLo   <= '0;
        end else begin
            enableWrite <= 1'b0;
            if (retire && wrRegWrite && (wrRd != '0)) begin
                enableWrite <= 1'b1;
                writeReg    <= wrRd;
                writeData   <= wrData;
            end
            case (state)
                IDLE: begin
                    if (acceptIdle && (in_wb_sel == WB_LOAD) && !mem_rvalid) begin
                        state        <= WAIT_LOAD;
                        pendRegWrite <= in_reg_write;
                        pendRd       <= in_rd;
                        pendFunct3   <= in_funct3;
                        pendAddrLo   <= in_addr_lo;
                    end
                end
                WAIT_LOAD: begin
                    if (flush || mem_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) retire_count <= '0;
        else if (retire) retire_count <= retire_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus4;
    logic [31:0] in_imm;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        enableWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        wb_busy;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retireCount;
`endif

    int vectors = 0;
    int miscompares = 0;
    int expRetire = 0;

    mem_wb_stage dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg_write  (in_reg_write),
        .in_rd         (in_rd),
        .in_wb_sel     (in_wb_sel),
        .in_funct3     (in_funct3),
        .in_addr_lo    (in_addr_lo),
        .in_alu_result (in_alu_result),
        .in_pc_plus4   (in_pc_plus4),
        .in_imm        (in_imm),
        .mem_rdata     (mem_rdata),
        .mem_rvalid    (mem_rvalid),
        .enableWrite   (enableWrite),
        .writeReg      (writeReg),
        .writeData     (writeData),
        .wb_busy       (wb_busy)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_count  (retireCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_retire(input string name);
`ifdef WB_RETIRE_CNT_EN
        vectors++;
        if (retireCount !== expRetire) begin
            miscompares++;
            $display("FAIL %s retire_count got %0d want %0d", name, retireCount, expRetire);
        end
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_reg_write = 1'b0; in_rd = '0;
        in_wb_sel = 2'b00; in_funct3 = '0; in_addr_lo = '0; in_alu_result = '0;
        in_pc_plus4 = '0; in_imm = '0; mem_rdata = '0; mem_rvalid = 1'b0;
        step();
        vectors++;
        if ({enableWrite, writeReg, writeData, wb_busy, in_ready} !== 39'd0) begin
            miscompares++;
            $display("FAIL reset outputs got ew=%b reg=%0d data=%h busy=%b rdy=%b want all 0",
                     enableWrite, writeReg, writeData, wb_busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release in_ready got %b want 1", in_ready);
        end
        check_retire("reset");
    endtask

    task automatic test_alu();
        @(negedge clk);
        in_valid = 1'b1; in_wb_sel = 2'b00; in_rd = 5'd5; in_reg_write = 1'b1;
        in_alu_result = 32'h12345678;
        step();
        vectors++;
        if (enableWrite !== 1'b1 || writeReg !== 5'd5 || writeData !== 32'h12345678) begin
            miscompares++;
            $display("FAIL alu_write got ew=%b reg=%0d data=%h want 1/5/12345678",
                     enableWrite, writeReg, writeData);
        end
        expRetire++;
        @(negedge clk);
        in_valid = 1'b0;
        step();
        vectors++;
        if (enableWrite !== 1'b0 || writeData !== 32'h12345678) begin
            miscompares++;
            $display("FAIL alu_pulse got ew=%b data=%h want 0/12345678", enableWrite, writeData);
        end
    endtask

    task automatic test_rd_zero();
        @(negedge clk);
        in_valid = 1'b1; in_wb_sel = 2'b00; in_rd = 5'd0; in_reg_write = 1'b1;
        in_alu_result = 32'hFFFFFFFF;
        step();
        vectors++;
        if (enableWrite !== 1'b0 || writeData !== 32'h12345678) begin
            miscompares++;
            $display("FAIL rd_zero got ew=%b data=%h want 0/12345678", enableWrite, writeData);
        end
        expRetire++;
        @(negedge clk);
        in_valid = 1'b0;
        check_retire("rd_zero");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid = 1'b1; in_reg_write = 1'b1; in_wb_sel = 2'b10; in_rd = 5'd7;
        in_pc_plus4 = 32'h00001004;
        step();
        vectors++;
        if (enableWrite !== 1'b1 || writeReg !== 5'd7 || writeData !== 32'h00001004) begin
            miscompares++;
            $display("FAIL b2b_pc4 got ew=%b reg=%0d data=%h want 1/7/00001004",
                     enableWrite, writeReg, writeData);
        end
        @(negedge clk);
        in_wb_sel = 2'b11; in_rd = 5'd8; in_imm = 32'hFFFFF800;
        step();
        vectors++;
        if (enableWrite !== 1'b1 || writeReg !== 5'd8 || writeData !== 32'hFFFFF800) begin
            miscompares++;
            $display("FAIL b2b_imm got ew=%b reg=%0d data=%h want 1/8/fffff800",
                     enableWrite, writeReg, writeData);
        end
        expRetire += 2;
        @(negedge clk);
        in_valid = 1'b0;
        step();
        vectors++;
        if (enableWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle ew got %b want 0", enableWrite);
        end
    endtask

    task automatic test_load_wait(input logic [2:0] f3, input logic [31:0] expData, input string name);
        @(negedge clk);
        in_valid = 1'b1; in_reg_write = 1'b1; in_wb_sel = 2'b01; in_funct3 = f3;
        in_addr_lo = 2'd2; in_rd = 5'd9; mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (in_ready !== 1'b0 || wb_busy !== 1'b1 || enableWrite !== 1'b0) begin
                miscompares++;
                $display("FAIL %s wait%0d got rdy=%b busy=%b ew=%b want 0/1/0",
                         name, i, in_ready, wb_busy, enableWrite);
            end
            @(negedge clk);
            in_valid = 1'b0; in_funct3 = 3'b010; in_addr_lo = 2'd0; in_rd = 5'd1;
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h0080FF11;
        step();
        vectors++;
        if (enableWrite !== 1'b1 || writeReg !== 5'd9 || writeData !== expData
            || in_ready !== 1'b1 || wb_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s data got ew=%b reg=%0d data=%h rdy=%b busy=%b want 1/9/%h/1/0",
                     name, enableWrite, writeReg, writeData, in_ready, wb_busy, expData);
        end
        expRetire++;
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    task automatic test_load_immediate();
        logic [2:0]  f3Tab   [7] = '{3'b001, 3'b101, 3'b001, 3'b010, 3'b000, 3'b100, 3'b011};
        logic [1:0]  addrTab [7] = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1, 2'd1};
        logic [31:0] expTab  [7] = '{32'hFFFF8001, 32'h00008001, 32'hFFFF8001, 32'h8001ABCD,
                                     32'hFFFFFFCD, 32'h000000AB, 32'h8001ABCD};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_reg_write = 1'b1; in_wb_sel = 2'b01; in_rd = 5'd20 + 5'(i);
            in_funct3 = f3Tab[i]; in_addr_lo = addrTab[i];
            mem_rvalid = 1'b1; mem_rdata = 32'h8001ABCD;
            step();
            vectors++;
            if (enableWrite !== 1'b1 || writeReg !== 5'd20 + 5'(i) || writeData !== expTab[i]
                || in_ready !== 1'b1 || wb_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL load_imm%0d got ew=%b reg=%0d data=%h rdy=%b busy=%b want 1/%0d/%h/1/0",
                         i, enableWrite, writeReg, writeData, in_ready, wb_busy, 20 + i, expTab[i]);
            end
            expRetire++;
        end
        @(negedge clk);
        in_valid = 1'b0; mem_rvalid = 1'b0;
        check_retire("load_imm");
    endtask

    task automatic test_flush_wait();
        @(negedge clk);
        in_valid = 1'b1; in_reg_write = 1'b1; in_wb_sel = 2'b01; in_funct3 = 3'b010;
        in_rd = 5'd10; mem_rvalid = 1'b0;
        step();
        vectors++;
        if (wb_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_wait_enter busy got %b want 1", wb_busy);
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        vectors++;
        if (enableWrite !== 1'b0 || wb_busy !== 1'b0 || in_ready !== 1'b1
            || writeData !== 32'h8001ABCD) begin
            miscompares++;
            $display("FAIL flush_wait got ew=%b busy=%b rdy=%b data=%h want 0/0/1/8001abcd",
                     enableWrite, wb_busy, in_ready, writeData);
        end
        @(negedge clk);
        flush = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic test_flush_idle_and_stray();
        @(negedge clk);
        in_valid = 1'b1; in_reg_write = 1'b1; in_wb_sel = 2'b00; in_rd = 5'd11;
        in_alu_result = 32'h00000055; flush = 1'b1;
        step();
        vectors++;
        if (enableWrite !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_idle got ew=%b rdy=%b want 0/1", enableWrite, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00000077;
        step();
        vectors++;
        if (enableWrite !== 1'b0 || wb_busy !== 1'b0 || writeData !== 32'h8001ABCD) begin
            miscompares++;
            $display("FAIL stray_rvalid got ew=%b busy=%b data=%h want 0/0/8001abcd",
                     enableWrite, wb_busy, writeData);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_retire("flush_idle");
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        in_valid = 1'b1; in_reg_write = 1'b1; in_wb_sel = 2'b01; in_funct3 = 3'b010;
        in_rd = 5'd12; mem_rvalid = 1'b0;
        step();
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({enableWrite, writeReg, writeData, wb_busy, in_ready} !== 39'd0) begin
            miscompares++;
            $display("FAIL reset_mid_wait got ew=%b reg=%0d data=%h busy=%b rdy=%b want all 0",
                     enableWrite, writeReg, writeData, wb_busy, in_ready);
        end
        expRetire = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        step();
        vectors++;
        if (enableWrite !== 1'b0 || wb_busy !== 1'b0 || in_ready !== 1'b1 || writeData !== 32'd0) begin
            miscompares++;
            $display("FAIL post_reset_stray got ew=%b busy=%b rdy=%b data=%h want 0/0/1/0",
                     enableWrite, wb_busy, in_ready, writeData);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_retire("reset_mid_wait");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_rd_zero();
        test_back_to_back();
        test_load_wait(3'b000, 32'hFFFFFF80, "lb_wait");
        test_load_wait(3'b100, 32'h00000080, "lbu_wait");
        test_load_immediate();
        test_flush_wait();
        test_flush_idle_and_stray();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
